// File: rtl/adder_pkg.sv
// Shared adder parameters so the adder and its result checker always agree on width.
package adder_pkg;
    localparam int ADDER_WIDTH = 64;
    localparam int CHK_CNT_W   = 16;
endpackage

// File: rtl/sub_cmp_half.sv
// One half of the carry-split check: subtract with borrow and compare against the expected operand.
module sub_cmp_half #(
    parameter int H = 32
) (
    input  logic [H:0]   minuend,
    input  logic [H-1:0] subtrahend,
    input  logic         borrow_in,
    input  logic [H-1:0] expected,
    output logic         borrow_out,
    output logic         match
);
    logic [H:0] diff_s;

    // Arithmetic is modulo 2^(H+1); the top bit is the borrow (or the extended MSB for the high half).
    always_comb begin
        diff_s     = minuend - {1'b0, subtrahend} - {{H{1'b0}}, borrow_in};
        borrow_out = diff_s[H];
        match      = (diff_s[H-1:0] == expected);
    end
endmodule

// File: rtl/adder_result_checker.sv
// Recomputes {cout, s} - b - cin over three pipeline stages and flags results that differ from a.
module adder_result_checker
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CNT_W = CHK_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    input  logic             clr,
    output logic             out_valid,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] chk_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int H = WIDTH / 2;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             v1_r;
    logic [WIDTH-1:0] a1_r, b1_r, s1_r;
    logic             cin1_r, cout1_r;

    logic             v2_r;
    logic             bor_lo_r, ok_lo_r, cout2_r;
    logic [H-1:0]     a_hi2_r, b_hi2_r, s_hi2_r;

    logic             bor_lo_s, ok_lo_s;
    logic             bor_hi_s, match_hi_s;
    logic             res_valid_s, res_err_s;
    logic [CNT_W-1:0] chk_base_s, err_base_s, chk_next_s, err_next_s;
    logic             sticky_base_s, sticky_next_s;

    // Stage 1 data capture; data may go stale while the valid bit is low.
    always_ff @(posedge clk) begin
        a1_r    <= a;
        b1_r    <= b;
        s1_r    <= s;
        cin1_r  <= cin;
        cout1_r <= cout;
    end

    sub_cmp_half #(.H(H)) u_lo (
        .minuend    ({1'b0, s1_r[H-1:0]}),
        .subtrahend (b1_r[H-1:0]),
        .borrow_in  (cin1_r),
        .expected   (a1_r[H-1:0]),
        .borrow_out (bor_lo_s),
        .match      (ok_lo_s)
    );

    // Stage 2 data: low-half verdict plus the upper halves still to be checked.
    always_ff @(posedge clk) begin
        bor_lo_r <= bor_lo_s;
        ok_lo_r  <= ok_lo_s;
        a_hi2_r  <= a1_r[WIDTH-1:H];
        b_hi2_r  <= b1_r[WIDTH-1:H];
        s_hi2_r  <= s1_r[WIDTH-1:H];
        cout2_r  <= cout1_r;
    end

    // cout rides as the extra minuend MSB; a correct result leaves that bit zero.
    sub_cmp_half #(.H(H)) u_hi (
        .minuend    ({cout2_r, s_hi2_r}),
        .subtrahend (b_hi2_r),
        .borrow_in  (bor_lo_r),
        .expected   (a_hi2_r),
        .borrow_out (bor_hi_s),
        .match      (match_hi_s)
    );

    // Final verdict and next counter/sticky state; clr clears before the current result counts.
    always_comb begin
        res_valid_s = v2_r;
        res_err_s   = v2_r & ~(ok_lo_r & match_hi_s & ~bor_hi_s);
        if (clr) begin
            chk_base_s    = CNT_ZERO;
            err_base_s    = CNT_ZERO;
            sticky_base_s = 1'b0;
        end else begin
            chk_base_s    = chk_count;
            err_base_s    = err_count;
            sticky_base_s = err_sticky;
        end
        if (res_valid_s && (chk_base_s != CNT_MAX)) begin
            chk_next_s = chk_base_s + CNT_ONE;
        end else begin
            chk_next_s = chk_base_s;
        end
        if (res_err_s && (err_base_s != CNT_MAX)) begin
            err_next_s = err_base_s + CNT_ONE;
        end else begin
            err_next_s = err_base_s;
        end
        sticky_next_s = sticky_base_s | res_err_s;
    end

    // Valid pipeline, registered verdict and status; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            out_valid  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            chk_count  <= CNT_ZERO;
            err_count  <= CNT_ZERO;
        end else begin
            v1_r       <= in_valid;
            v2_r       <= v1_r;
            out_valid  <= res_valid_s;
            err        <= res_err_s;
            err_sticky <= sticky_next_s;
            chk_count  <= chk_next_s;
            err_count  <= err_next_s;
        end
    end
endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Consumer-side checker for the registered WIDTH-bit adder. It takes each operand set together with the adder's claimed {cout, s} and recomputes {cout, s} − b − cin in a carry-split pipeline.
- Flags any result that does not equal {0, a}, and keeps sticky error status plus saturating check and error counters for fault-injection labs.
- Sits beside the adder output register, one transaction per cycle, no backpressure.

Parameters:
- WIDTH, 64, operand/result width; must be even, ≥ 2.
- CNT_W, 16, width of the check and error counters.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  a/b/cin/s/cout are a transaction this cycle
- a  input  WIDTH  first operand presented to adder
- b  input  WIDTH  second operand presented to adder
- cin  input  1  carry-in presented to adder
- s  input  WIDTH  adder sum under test
- cout  input  1  adder carry-out under test
- clr  input  1  synchronous clear of err_sticky and counters
- out_valid  output  1  check result valid this cycle
- err  output  1  mismatch on this result; qualified by out_valid
- err_sticky  output  1  set on any mismatch since reset/clr
- chk_count  output  CNT_W  results checked, saturating
- err_count  output  CNT_W  mismatches, saturating

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high.
- Reset values: out_valid=0, err=0, err_sticky=0, chk_count=0, err_count=0. All pipeline valid bits are 0.
- Latency is exactly 3 cycles, in_valid at edge N → out_valid at edge N+3. Throughput is 1 per cycle; in_valid may be held high indefinitely.
- Stage 1 (input register): capture a, b, cin, s, cout and valid unconditionally. Data regs may hold stale values while valid=0.
- Stage 2 (low half), H=WIDTH/2:
  - {bor_lo, d_lo} = s[H-1:0] − b[H-1:0] − cin, computed with H+1 bits.
  - ok_lo = (d_lo == a[H-1:0]).
  - Register bor_lo, ok_lo, the upper halves of a, b and s, cout, and valid.
- Stage 3 (high half):
  - d_hi = {cout, s[W-1:H]} − {0, b[W-1:H]} − bor_lo, computed with H+1 bits.
  - ok_hi = (d_hi == {0, a[W-1:H]}).
  - Register out_valid = valid and err = valid & ~(ok_lo & ok_hi).
- err is 0 whenever out_valid is 0.
- Arithmetic: all subtraction is modulo 2^(H+1). cout=1 with a correct sum requires d_hi's top bit to be 0; any cout mismatch flags err.
- Counters update on the same edge as out_valid/err. The counter inputs are the stage-3 combinational result, so the updated counts are visible together with out_valid.
  - chk_count += 1 when a result is valid.
  - err_count += 1 when a result is valid and mismatched.
  - Both saturate at 2^CNT_W − 1 and never wrap.
- err_sticky: set by a mismatched valid result; held until rst or clr.
- clr coinciding with a result: clear applies first, then the current result. chk_count becomes 1, err_count becomes err, err_sticky becomes err.
- clr with no result: counters and err_sticky go to 0. The pipeline is unaffected.
- rst mid-operation: all in-flight transactions are discarded. No out_valid occurs for inputs accepted within the 3 cycles before reset deasserts. in_valid sampled while rst=1 is ignored.
- X-safety: data registers need no reset. Only valid bits, err, err_sticky and the counters are reset.

Decomposition:
- Shared package (adder_pkg): ADDER_WIDTH=64 default and CHK_CNT_W=16. The adder and the checker both take WIDTH from it so the two ends cannot diverge.
- One sub-module, sub_cmp_half: a parameterised H-bit subtract-with-borrow-and-compare. Inputs are minuend, subtrahend, borrow_in and expected; outputs are borrow_out and match.
  - It is instantiated twice. The high instance gets cout as the extra minuend MSB, and its expected value has a zero MSB.

Test Plan:
- Correct result: a=0x0000_0000_FFFF_FFFF, b=1, cin=0, s=0x0000_0001_0000_0000, cout=0, in_valid for 1 cycle → out_valid at +3, err=0, chk_count=1, err_count=0 (exercises the low→high borrow).
- Carry-out: a=b=0xFFFF_FFFF_FFFF_FFFF, cin=1, s=0xFFFF_FFFF_FFFF_FFFF, cout=1 → err=0. The same transaction with cout=0 → err=1, err_sticky=1, err_count=1.
- Single bit fault: a=5, b=3, cin=0, s=8 with bit 40 flipped → err=1. Back-to-back streaming of 100 correct vectors with 3 injected faults → chk_count=100, err_count=3, exactly 3 err pulses aligned with the faulty vectors +3 cycles.
- Saturation: CNT_W=4, 20 consecutive faulty transactions → chk_count=15 and err_count=15, both holding at 15.
- clr in the same cycle as a faulty out_valid: prior err_count=7 → err_count=1, chk_count=1, err_sticky=1. clr on an idle cycle → all three go to 0.
- Reset mid-stream: in_valid high continuously, rst asserted for 1 cycle after 2 transactions → no out_valid for transactions presented during or in the 2 cycles before reset. The first out_valid occurs 3 cycles after the first post-reset in_valid, and all counters restart at 0.
